// File: rtl/mem_pkg.sv
// Shared memory-side types: arbiter states, port select, and the byte-merge helper.
// RMW states exist only when MEM_ARB_RMW_EN is defined.
package mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_REL
`ifdef MEM_ARB_RMW_EN
    , ST_RMW_RD
    , ST_RMW_REL
    , ST_RMW_WR
`endif
  } arb_state_t;

  typedef enum logic {
    PORT_IF,
    PORT_DM
  } port_sel_t;

  // Bytes of new_word where be is set, bytes of old_word elsewhere.
  function automatic logic [31:0] byte_merge(input logic [31:0] new_word,
                                             input logic [31:0] old_word,
                                             input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[i*8 +: 8] = be[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
    return res;
  endfunction

endpackage

// File: rtl/mem_byte_merge.sv
// Combinational 32-bit byte merge under a 4-bit enable; used by the RMW write path.
module mem_byte_merge
  import mem_pkg::*;
(
  input  logic [31:0] new_word,
  input  logic [31:0] old_word,
  input  logic [3:0]  be,
  output logic [31:0] merged
);

  assign merged = byte_merge(new_word, old_word, be);

endmodule

// File: rtl/mem_req_arbiter.sv
// Two-port (fetch / data) arbiter onto a single req/ack memory bus.
// Define MEM_ARB_RMW_EN to turn partial-byte writes into read-modify-write sequences.
//
// state      | meaning
// IDLE       | sample requests, grant one, register address/data
// REQ        | ren or wen held until ack
// REL        | strobes low, wait for ack to drop
// RMW_RD     | read old word for a partial write
// RMW_REL    | wait for ack to drop between read and write
// RMW_WR     | write merged word
module mem_req_arbiter
  import mem_pkg::*;
#(
  parameter int DM_BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        dm_ren,
  input  logic        dm_wen,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_be,
  output logic        dm_done,
  output logic [31:0] dm_rdata,
  output logic [31:0] addr,
  output logic [31:0] data_i,
  output logic        ren,
  output logic        wen,
  input  logic        ack,
  input  logic [31:0] data_o
);

  localparam int CW = $clog2(DM_BURST_MAX + 1);

  arb_state_t     state, state_nxt;
  port_sel_t      sel_q;
  logic           wr_q;
  logic [CW-1:0]  burst_cnt;
  logic           dm_pend, if_win, dm_win;

  assign dm_pend = dm_ren | dm_wen;
  assign if_win  = if_req && (!dm_pend || burst_cnt >= CW'(DM_BURST_MAX));
  assign dm_win  = dm_pend && !if_win;

`ifdef MEM_ARB_RMW_EN
  logic [3:0]  be_q;
  logic [31:0] merged;

  mem_byte_merge u_merge (
    .new_word (data_i),
    .old_word (data_o),
    .be       (be_q),
    .merged   (merged)
  );
`else
  logic unused_be;
  assign unused_be = ^dm_be;
`endif

  always_comb begin
    state_nxt = state;
    ren       = 1'b0;
    wen       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (if_win) state_nxt = ST_REQ;
        else if (dm_win) begin
          state_nxt = ST_REQ;
`ifdef MEM_ARB_RMW_EN
          // Both strobes high is a read, so only a pure write can need RMW.
          if (dm_wen && !dm_ren && dm_be != 4'hF)
            state_nxt = (dm_be == 4'h0) ? ST_REL : ST_RMW_RD;
`endif
        end
      end
      ST_REQ: begin
        ren = !wr_q;
        wen = wr_q;
        if (ack) state_nxt = ST_REL;
      end
      ST_REL: if (!ack) state_nxt = ST_IDLE;
`ifdef MEM_ARB_RMW_EN
      ST_RMW_RD: begin
        ren = 1'b1;
        if (ack) state_nxt = ST_RMW_REL;
      end
      ST_RMW_REL: if (!ack) state_nxt = ST_RMW_WR;
      ST_RMW_WR: begin
        wen = 1'b1;
        if (ack) state_nxt = ST_REL;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      sel_q     <= PORT_IF;
      wr_q      <= 1'b0;
      burst_cnt <= '0;
      addr      <= '0;
      data_i    <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
`ifdef MEM_ARB_RMW_EN
      be_q      <= '0;
`endif
    end else begin
      state   <= state_nxt;
      if_done <= 1'b0;
      dm_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (if_win) begin
            sel_q     <= PORT_IF;
            wr_q      <= 1'b0;
            addr      <= if_addr;
            burst_cnt <= '0;
          end else if (dm_win) begin
            sel_q  <= PORT_DM;
            wr_q   <= !dm_ren;
            addr   <= dm_addr;
            data_i <= dm_wdata;
            if (burst_cnt < CW'(DM_BURST_MAX)) burst_cnt <= burst_cnt + 1'b1;
`ifdef MEM_ARB_RMW_EN
            be_q <= dm_be;
            if (!dm_ren && dm_be == 4'h0) dm_done <= 1'b1;
`endif
          end
        end
        ST_REQ: begin
          if (ack) begin
            if (sel_q == PORT_IF) begin
              if_done  <= 1'b1;
              if_rdata <= data_o;
            end else begin
              dm_done <= 1'b1;
              if (!wr_q) dm_rdata <= data_o;
            end
          end
        end
`ifdef MEM_ARB_RMW_EN
        ST_RMW_RD: if (ack) data_i <= merged;
        ST_RMW_WR: if (ack) dm_done <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: vector table plus corner-case sequences,
// with a downstream responder that checks bus transactions against a scoreboard queue.
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_done, dm_ren, dm_wen, dm_done, ren, wen, ack;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata, addr, data_i, data_o;
  logic [3:0]  dm_be;

  always #5 clk = ~clk;

  mem_req_arbiter #(.DM_BURST_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .dm_ren(dm_ren), .dm_wen(dm_wen), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .addr(addr), .data_i(data_i), .ren(ren), .wen(wen), .ack(ack), .data_o(data_o)
  );

  typedef struct { logic wr; logic [31:0] addr; logic [31:0] data; } bus_t;
  typedef struct {
    int kind;  // 0 fetch, 1 dm read, 2 dm write, 3 dm read+write
    logic [31:0] addr; logic [31:0] wdata; logic [31:0] rsp;
    int dly; int hold; logic exp_wr;
  } vec_t;

  bus_t        sb[$];
  int          checks = 0, errors = 0;
  int          if_done_cnt = 0, dm_done_cnt = 0, bus_cnt = 0;
  int          strobe_len = 0, last_strobe_len = 0;
  int          ack_dly = 1, ack_hold = 1;
  bit          gap_chk_en = 1'b1;
  logic [31:0] resp = '0;
  logic [31:0] exp_if = '0, exp_dm = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Downstream responder and bus monitor, all at the falling edge.
  initial begin : responder
    int   cnt, hold;
    logic prev_ack, prev_strobe;
    bus_t e;
    cnt = 0; hold = 0; prev_ack = 1'b0; prev_strobe = 1'b0;
    ack = 1'b0; data_o = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (if_done | dm_done) chk("done_exclusive", 32'(if_done & dm_done), 32'd0);
        if (if_done) if_done_cnt++;
        if (dm_done) dm_done_cnt++;
        if ((ren | wen) && !prev_strobe && gap_chk_en)
          chk("strobe_gap_after_ack", 32'(ack | prev_ack), 32'd0);
        if (ren | wen) strobe_len++;
        else if (prev_strobe) begin last_strobe_len = strobe_len; strobe_len = 0; end
      end
      prev_ack = ack;
      prev_strobe = ren | wen;
      if (rst) begin
        ack = 1'b0; cnt = 0; hold = 0; strobe_len = 0;
      end else if (ack) begin
        hold++;
        if (hold >= ack_hold) begin ack = 1'b0; hold = 0; cnt = 0; data_o = 32'hBAD0_BAD0; end
      end else if (ren | wen) begin
        cnt++;
        if (cnt >= ack_dly) begin
          ack = 1'b1; data_o = resp; bus_cnt++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL bus_unexpected: actual addr=%h required=no access", addr);
          end else begin
            e = sb.pop_front();
            chk("bus_one_strobe", 32'(ren ^ wen), 32'd1);
            chk("bus_wr", 32'(wen), 32'(e.wr));
            chk("bus_addr", addr, e.addr);
            if (e.wr) chk("bus_data", data_i, e.data);
          end
        end
      end else cnt = 0;
    end
  end

  task automatic run_xact(input int kind, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input logic [31:0] rsp,
                          input int dly, input int hold, input bit chk_len);
    int if0, dm0;
    bit got, scr;
    if0 = if_done_cnt; dm0 = dm_done_cnt; got = 1'b0; scr = 1'b0;
    ack_dly = dly; ack_hold = hold; resp = rsp;
    if_addr = a; dm_addr = a; dm_wdata = wd; dm_be = be;
    if_req = (kind == 0);
    dm_ren = (kind == 1 || kind == 3);
    dm_wen = (kind == 2 || kind == 3);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if ((ren | wen) && !scr) begin
        if_addr = ~a; dm_addr = ~a; dm_wdata = ~wd; scr = 1'b1;
      end
      if ((kind == 0 && if_done) || (kind != 0 && dm_done)) got = 1'b1;
      if (got) break;
    end
    if_req = 1'b0; dm_ren = 1'b0; dm_wen = 1'b0;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout: actual=no done required=done (kind %0d)", kind);
    end
    for (int i = 0; i < 50; i++) begin
      if (!ack) break;
      @(negedge clk); #1;
    end
    repeat (2) @(negedge clk);
    #1;
    chk("if_done_pulses", 32'(if_done_cnt - if0), (kind == 0) ? 32'd1 : 32'd0);
    chk("dm_done_pulses", 32'(dm_done_cnt - dm0), (kind == 0) ? 32'd0 : 32'd1);
    if (chk_len) chk("strobe_len", 32'(last_strobe_len), 32'(dly));
  endtask

  task automatic check_reset_outputs();
    chk("rst_ren", 32'(ren), 32'd0);
    chk("rst_wen", 32'(wen), 32'd0);
    chk("rst_if_done", 32'(if_done), 32'd0);
    chk("rst_dm_done", 32'(dm_done), 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_data_i", data_i, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
  endtask

  initial begin : main
    vec_t tv[7];
    int   b0, if0, dm0;
    bit   seen;

    tv[0] = '{0, 32'h1FC0_0000, 32'h0,         32'h3C08_0013, 3, 1, 1'b0};
    tv[1] = '{2, 32'h8000_1000, 32'hDEAD_BEEF, 32'h0,         1, 2, 1'b1};
    tv[2] = '{1, 32'h8000_1000, 32'h0,         32'h1234_5678, 1, 1, 1'b0};
    tv[3] = '{3, 32'h0000_0040, 32'h5555_5555, 32'h0BAD_F00D, 2, 1, 1'b0};
    tv[4] = '{0, 32'h1FC0_0004, 32'h0,         32'h27BD_FFE8, 5, 3, 1'b0};
    tv[5] = '{2, 32'h0000_0FFC, 32'h0000_0001, 32'h0,         4, 1, 1'b1};
    tv[6] = '{1, 32'h7FFF_FFFC, 32'h0,         32'hFFFF_FFFF, 1, 4, 1'b0};

    rst = 1'b1; if_req = 0; dm_ren = 0; dm_wen = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_be = 4'hF;
    repeat (2) @(negedge clk);
    #1 check_reset_outputs();
    rst = 1'b0;
    @(negedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      sb.push_back('{tv[i].exp_wr, tv[i].addr, tv[i].wdata});
      run_xact(tv[i].kind, tv[i].addr, tv[i].wdata, 4'hF, tv[i].rsp, tv[i].dly, tv[i].hold, 1'b1);
      if (tv[i].kind == 0) exp_if = tv[i].rsp;
      else if (tv[i].kind != 2) exp_dm = tv[i].rsp;
      chk("if_rdata", if_rdata, exp_if);
      chk("dm_rdata", dm_rdata, exp_dm);
    end

    // Partial-byte write, then an all-disabled write.
    gap_chk_en = 1'b0;
`ifdef MEM_ARB_RMW_EN
    sb.push_back('{1'b0, 32'h0000_0100, 32'h0});
    sb.push_back('{1'b1, 32'h0000_0100, 32'h1122_CC44});
`else
    sb.push_back('{1'b1, 32'h0000_0100, 32'hAABB_CCDD});
`endif
    run_xact(2, 32'h0000_0100, 32'hAABB_CCDD, 4'b0010, 32'h1122_3344, 1, 1, 1'b0);
    chk("rmw_dm_rdata_held", dm_rdata, exp_dm);
    b0 = bus_cnt;
`ifndef MEM_ARB_RMW_EN
    sb.push_back('{1'b1, 32'h0000_0104, 32'hCAFE_F00D});
`endif
    run_xact(2, 32'h0000_0104, 32'hCAFE_F00D, 4'h0, 32'h0, 1, 1, 1'b0);
`ifdef MEM_ARB_RMW_EN
    chk("be0_bus_accesses", 32'(bus_cnt - b0), 32'd0);
`else
    chk("be0_bus_accesses", 32'(bus_cnt - b0), 32'd1);
`endif
    gap_chk_en = 1'b1;

    // Fresh burst counter, both ports held: D,D,D,D,I,D,D,D,D,I.
    rst = 1'b1; #1 check_reset_outputs();
    @(negedge clk); #1 rst = 1'b0;
    for (int g = 0; g < 10; g++)
      sb.push_back('{1'b0, (g % 5 == 4) ? 32'h0000_0100 : 32'h0000_0200, 32'h0});
    resp = 32'h600D_0200; ack_dly = 1; ack_hold = 2;
    b0 = bus_cnt; if0 = if_done_cnt; dm0 = dm_done_cnt;
    if_addr = 32'h0000_0100; dm_addr = 32'h0000_0200;
    if_req = 1'b1; dm_ren = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (bus_cnt - b0 >= 10) break;
    end
    if_req = 1'b0; dm_ren = 1'b0;
    if (bus_cnt - b0 < 10) begin
      errors++;
      $display("FAIL burst_timeout: actual=%0d grants required=10", bus_cnt - b0);
    end
    repeat (8) @(negedge clk);
    #1;
    chk("burst_if_done", 32'(if_done_cnt - if0), 32'd2);
    chk("burst_dm_done", 32'(dm_done_cnt - dm0), 32'd8);
    chk("burst_if_rdata", if_rdata, 32'h600D_0200);

    // Reset while REQ is waiting for a slow ack.
    ack_dly = 20; ack_hold = 1;
    if0 = if_done_cnt; seen = 1'b0;
    if_addr = 32'h1FC0_0008; if_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (ren) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      errors++;
      $display("FAIL midrst_no_ren: actual=ren low required=ren high");
    end
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1 check_reset_outputs();
    @(negedge clk); #1 rst = 1'b0; if_req = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("midrst_no_done", 32'(if_done_cnt - if0), 32'd0);
    chk("midrst_ren", 32'(ren), 32'd0);
    sb.push_back('{1'b0, 32'h1FC0_000C, 32'h0});
    run_xact(0, 32'h1FC0_000C, 32'h0, 4'hF, 32'h0800_0040, 2, 1, 1'b1);
    chk("recover_if_rdata", if_rdata, 32'h0800_0040);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameter: DM_BURST_MAX, 4, maximum consecutive data-port grants while if_req is pending.
REQ-002 clk  input  1  clock; rst  input  1  reset, asynchronous, active-high.
REQ-003 if_req  input  1  instruction-fetch read request, held until if_done.
REQ-004 if_addr  input  32  fetch byte address, word-aligned.
REQ-005 if_done  output  1  one-cycle pulse: fetch complete, if_rdata valid.
REQ-006 if_rdata  output  32  fetched word, held until the next fetch completes.
REQ-007 dm_ren, dm_wen  input  1 each  data-port read and write requests, held until dm_done.
REQ-008 dm_addr  input  32  data byte address; dm_wdata  input  32  write data; dm_be  input  4  byte enables.
REQ-009 dm_done  output  1  one-cycle pulse: data access complete; dm_rdata  output  32  read word, held.
REQ-010 addr, data_i  output  32 each  downstream address and write data.
REQ-011 ren, wen  output  1 each  downstream request strobes.
REQ-012 ack  input  1  downstream acknowledge; data_o  input  32  downstream read data.

Function
REQ-013 States: IDLE, REQ, REL; RMW_RD, RMW_REL and RMW_WR exist only under REQ-027.
REQ-014 IDLE samples requests; with no request, all strobes stay 0.
REQ-015 Arbitration: data port wins, unless if_req is pending and DM_BURST_MAX consecutive data grants have already occurred; a fetch grant clears the burst counter.
REQ-016 On grant, addr/data_i are registered from the winning port and held constant through REQ and REL; next state is REQ.
REQ-017 REQ: exactly one of ren/wen is high and held until ack=1.
REQ-018 On the ack=1 cycle: drop ren/wen next cycle; capture data_o into if_rdata/dm_rdata for reads; pulse if_done or dm_done next cycle; go to REL.
REQ-019 REL: ren=wen=0; stay until ack=0, then go to IDLE; no new grant while ack=1.
REQ-020 Minimum inter-request gap: one idle strobe cycle after ack falls.
REQ-021 dm_ren and dm_wen both high: treated as a read; the write is not performed.
REQ-022 A request still high in the cycle after its done pulse is a new request.
REQ-023 Client address/data changes during REQ/REL are ignored (registered copies used).
REQ-024 if_done and dm_done are never high in the same cycle.

Reset
REQ-025 rst asserted: state IDLE; ren, wen, if_done, dm_done = 0; addr, data_i, if_rdata, dm_rdata = 0; burst counter = 0; takes effect immediately, in any state.
REQ-026 rst mid-transaction abandons the transaction with no done pulse; clients must reissue.

Configuration
REQ-027 MEM_ARB_RMW_EN defined, write with dm_be != 4'hF: RMW_RD (ren until ack, latch data_o) -> RMW_REL (wait ack=0) -> RMW_WR (merged word: dm_wdata bytes where dm_be=1, else read bytes; wen until ack) -> REL; dm_done pulses once, after the write ack.
REQ-028 MEM_ARB_RMW_EN defined, dm_be = 4'h0: dm_done pulses one cycle after grant, with no downstream access.
REQ-029 MEM_ARB_RMW_EN undefined: dm_be ignored; every write is a single full-word write of dm_wdata.

Structure
REQ-030 State enum, port-select enum, and a byte-merge function belong in the shared memory package mem_pkg.
REQ-031 Sub-module mem_byte_merge (combinational 32-bit merge by 4-bit enable) is instantiated only under MEM_ARB_RMW_EN.

Verification
REQ-032 if_req, if_addr=0x1FC00000; ack after 3 cycles, data_o=0x3C080013 -> ren high 3 cycles, if_rdata=0x3C080013, single if_done pulse.
REQ-033 dm_wen, dm_addr=0x80001000, dm_wdata=0xDEADBEEF, be=F -> wen until ack, data_i=0xDEADBEEF, dm_done; ack held 2 cycles -> no new strobe until ack=0.
REQ-034 if_req and dm_ren held continuously, DM_BURST_MAX=4 -> grant order D,D,D,D,I repeating; never two done pulses in one cycle.
REQ-035 RMW on: read returns 0x11223344, dm_wdata=0xAABBCCDD, be=4'b0010 -> written word 0x1122CC44, one dm_done; RMW off -> written word 0xAABBCCDD.
REQ-036 rst pulsed while in REQ with ren=1 -> ren=0 immediately, no done pulse; after release, a new if_req completes normally.
